// File: rtl/axis_demux_lb_sched_if.sv
// Snoop/control bundle between an axis_demux and its load-balancing scheduler.
// master: scheduler (reads mon_*, drives dmx_*); slave: demux side.
interface axis_demux_lb_sched_if #(
    parameter int SEL_WIDTH = 2
);
    logic                 mon_tvalid;
    logic                 mon_tready;
    logic                 mon_tlast;
    logic                 dmx_enable;
    logic                 dmx_drop;
    logic [SEL_WIDTH-1:0] dmx_select;

    modport master (
        input  mon_tvalid, mon_tready, mon_tlast,
        output dmx_enable, dmx_drop, dmx_select
    );

    modport slave (
        output mon_tvalid, mon_tready, mon_tlast,
        input  dmx_enable, dmx_drop, dmx_select
    );
endinterface

// File: rtl/axis_demux_lb_sched.sv
// Frame-level round-robin scheduler with per-output credits for an axis_demux.
// Ports: clk/rst, bus (snoop + demux controls), i_port_en, i_done,
//        o_credit_cnt, o_stat_drop_cnt, o_err_underflow.
module axis_demux_lb_sched #(
    parameter int M_COUNT           = 4,
    parameter int SEL_WIDTH         = $clog2(M_COUNT),
    parameter int CREDIT_WIDTH      = 4,
    parameter int CREDIT_MAX        = 8,
    parameter bit DROP_WHEN_BLOCKED = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst,
    axis_demux_lb_sched_if.master           bus,
    input  logic [M_COUNT-1:0]              i_port_en,
    input  logic [M_COUNT-1:0]              i_done,
    output logic [M_COUNT*CREDIT_WIDTH-1:0] o_credit_cnt,
    output logic [31:0]                     o_stat_drop_cnt,
    output logic                            o_err_underflow
);
    typedef enum logic [1:0] {ARB, READY, BUSY} state_t;

    state_t                  r_state, w_state;
    logic                    r_enable, w_enable;
    logic                    r_drop, w_drop;
    logic [SEL_WIDTH-1:0]    r_sel, w_sel;
    logic [SEL_WIDTH-1:0]    r_rr, w_rr;
    logic [CREDIT_WIDTH-1:0] r_cnt [M_COUNT];
    logic [31:0]             r_drop_cnt;
    logic                    r_err;

    logic                    w_hs;
    logic                    w_dispatch;
    logic [M_COUNT-1:0]      w_elig;
    logic [M_COUNT-1:0]      w_inc;
    logic                    w_hi, w_lo;
    logic [SEL_WIDTH-1:0]    w_hi_idx, w_lo_idx, w_grant;

    assign w_hs       = bus.mon_tvalid & bus.mon_tready;
    // Only the first beat of a frame consumes a credit or a drop count.
    assign w_dispatch = w_hs & (r_state == READY);

    // Round-robin: lowest eligible index above r_rr, else lowest overall.
    always_comb begin
        w_hi     = 1'b0;
        w_lo     = 1'b0;
        w_hi_idx = '0;
        w_lo_idx = '0;
        w_elig   = '0;
        w_inc    = '0;
        for (int i = 0; i < M_COUNT; i++) begin
            w_elig[i] = i_port_en[i] &
                        (r_cnt[i] < CREDIT_WIDTH'(CREDIT_MAX));
            w_inc[i]  = w_dispatch & ~r_drop &
                        (r_sel == SEL_WIDTH'(i));
        end
        for (int i = M_COUNT - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                if (i > int'(r_rr)) begin
                    w_hi     = 1'b1;
                    w_hi_idx = SEL_WIDTH'(i);
                end else begin
                    w_lo     = 1'b1;
                    w_lo_idx = SEL_WIDTH'(i);
                end
            end
        end
        w_grant = w_hi ? w_hi_idx : w_lo_idx;
    end

    always_comb begin
        w_state  = r_state;
        w_enable = r_enable;
        w_drop   = r_drop;
        w_sel    = r_sel;
        w_rr     = r_rr;
        unique case (r_state)
            ARB: begin
                if (w_hi | w_lo) begin
                    w_sel    = w_grant;
                    w_rr     = w_grant;
                    w_drop   = 1'b0;
                    w_enable = 1'b1;
                    w_state  = READY;
                end else if (DROP_WHEN_BLOCKED) begin
                    w_drop   = 1'b1;
                    w_enable = 1'b1;
                    w_state  = READY;
                end else begin
                    w_enable = 1'b0;
                end
            end
            READY: begin
                if (w_hs) begin
                    if (bus.mon_tlast) begin
                        w_enable = 1'b0;
                        w_state  = ARB;
                    end else begin
                        w_state  = BUSY;
                    end
                end
            end
            BUSY: begin
                if (w_hs && bus.mon_tlast) begin
                    w_enable = 1'b0;
                    w_state  = ARB;
                end
            end
            default: w_state = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB;
            r_enable   <= 1'b0;
            r_drop     <= 1'b0;
            r_sel      <= '0;
            r_rr       <= SEL_WIDTH'(M_COUNT - 1);
            r_drop_cnt <= '0;
            r_err      <= 1'b0;
            for (int i = 0; i < M_COUNT; i++) r_cnt[i] <= '0;
        end else begin
            r_state  <= w_state;
            r_enable <= w_enable;
            r_drop   <= w_drop;
            r_sel    <= w_sel;
            r_rr     <= w_rr;
            if (w_dispatch && r_drop && (r_drop_cnt != 32'hFFFF_FFFF))
                r_drop_cnt <= r_drop_cnt + 32'd1;
            // A dispatch and a done on the same port cancel out.
            for (int i = 0; i < M_COUNT; i++) begin
                if (w_inc[i] && !i_done[i]) begin
                    if (r_cnt[i] < CREDIT_WIDTH'(CREDIT_MAX))
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (i_done[i] && !w_inc[i]) begin
                    if (r_cnt[i] == '0)
                        r_err <= 1'b1;
                    else
                        r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_credit_cnt = '0;
        for (int i = 0; i < M_COUNT; i++)
            o_credit_cnt[i*CREDIT_WIDTH +: CREDIT_WIDTH] = r_cnt[i];
    end

    assign bus.dmx_enable  = r_enable;
    assign bus.dmx_drop    = r_drop;
    assign bus.dmx_select  = r_sel;
    assign o_stat_drop_cnt = r_drop_cnt;
    assign o_err_underflow = r_err;
endmodule

// File: tb/tb_axis_demux_lb_sched.sv
// Directed bench for axis_demux_lb_sched.
// Three instances: default, CREDIT_MAX=2 stall, CREDIT_MAX=2 drop.
module tb_axis_demux_lb_sched;
    logic       clk;
    logic       rst;
    logic       s_valid;
    logic       s_last;
    int         tgt;
    logic [3:0] port_en;
    logic [3:0] done;

    logic [15:0] cc_a, cc_b, cc_c;
    logic [31:0] dc_a, dc_b, dc_c;
    logic        er_a, er_b, er_c;

    int   checks;
    int   errors;
    logic b_got;
    logic [1:0] b_sel;
    logic b_drop;

    axis_demux_lb_sched_if #(.SEL_WIDTH(2)) ifa ();
    axis_demux_lb_sched_if #(.SEL_WIDTH(2)) ifb ();
    axis_demux_lb_sched_if #(.SEL_WIDTH(2)) ifc ();

    assign ifa.mon_tvalid = s_valid && (tgt == 0);
    assign ifb.mon_tvalid = s_valid && (tgt == 1);
    assign ifc.mon_tvalid = s_valid && (tgt == 2);
    assign ifa.mon_tready = ifa.dmx_enable;
    assign ifb.mon_tready = ifb.dmx_enable;
    assign ifc.mon_tready = ifc.dmx_enable;
    assign ifa.mon_tlast  = s_last;
    assign ifb.mon_tlast  = s_last;
    assign ifc.mon_tlast  = s_last;

    axis_demux_lb_sched dut_a (
        .clk(clk), .rst(rst), .bus(ifa.master),
        .i_port_en(port_en), .i_done(done),
        .o_credit_cnt(cc_a), .o_stat_drop_cnt(dc_a),
        .o_err_underflow(er_a)
    );

    axis_demux_lb_sched #(
        .CREDIT_MAX(2), .DROP_WHEN_BLOCKED(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.master),
        .i_port_en(port_en), .i_done(done),
        .o_credit_cnt(cc_b), .o_stat_drop_cnt(dc_b),
        .o_err_underflow(er_b)
    );

    axis_demux_lb_sched #(
        .CREDIT_MAX(2), .DROP_WHEN_BLOCKED(1'b1)
    ) dut_c (
        .clk(clk), .rst(rst), .bus(ifc.master),
        .i_port_en(port_en), .i_done(done),
        .o_credit_cnt(cc_c), .o_stat_drop_cnt(dc_c),
        .o_err_underflow(er_c)
    );

    logic       t_en;
    logic [1:0] t_sel;
    logic       t_drop;
    assign t_en   = (tgt == 0) ? ifa.dmx_enable :
                    (tgt == 1) ? ifb.dmx_enable : ifc.dmx_enable;
    assign t_sel  = (tgt == 0) ? ifa.dmx_select :
                    (tgt == 1) ? ifb.dmx_select : ifc.dmx_select;
    assign t_drop = (tgt == 0) ? ifa.dmx_drop :
                    (tgt == 1) ? ifb.dmx_drop : ifc.dmx_drop;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_all();
        s_valid = 1'b0;
        s_last  = 1'b0;
        done    = 4'h0;
        rst     = 1'b1;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
    endtask

    // One beat on the target instance; records controls at the handshake.
    task automatic beat(input logic last);
        s_valid = 1'b1;
        s_last  = last;
        b_got   = 1'b0;
        for (int i = 0; i < 20 && !b_got; i++) begin
            #1;
            if (t_en) begin
                b_got  = 1'b1;
                b_sel  = t_sel;
                b_drop = t_drop;
            end
            @(posedge clk);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("beat_handshake", {31'd0, b_got}, 32'd1);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        tgt     = 0;
        port_en = 4'hF;
        b_sel   = '0;
        b_drop  = 1'b0;
        reset_all();

        // reset state
        chk("rst_enable", {31'd0, ifa.dmx_enable}, 32'd0);
        chk("rst_drop",   {31'd0, ifa.dmx_drop},   32'd0);
        chk("rst_select", {30'd0, ifa.dmx_select}, 32'd0);
        chk("rst_credit", {16'd0, cc_a}, 32'd0);
        chk("rst_dropcnt", dc_a, 32'd0);
        chk("rst_err", {31'd0, er_a}, 32'd0);

        // round robin over 3 one-beat frames
        beat(1'b1);
        chk("t1_sel0", {30'd0, b_sel}, 32'd0);
        beat(1'b1);
        chk("t1_sel1", {30'd0, b_sel}, 32'd1);
        beat(1'b1);
        chk("t1_sel2", {30'd0, b_sel}, 32'd2);
        chk("t1_credit", {16'd0, cc_a}, 32'h0111);

        // port_en change mid-frame only affects the next arbitration
        reset_all();
        beat(1'b1);
        chk("t4_pre_sel", {30'd0, b_sel}, 32'd0);
        beat(1'b0);
        chk("t4_beat1_sel", {30'd0, b_sel}, 32'd1);
        beat(1'b0);
        port_en = 4'b1101;
        beat(1'b0);
        beat(1'b0);
        beat(1'b1);
        chk("t4_beat5_sel", {30'd0, b_sel}, 32'd1);
        chk("t4_gap_enable", {31'd0, ifa.dmx_enable}, 32'd0);
        beat(1'b1);
        chk("t4_next_sel", {30'd0, b_sel}, 32'd2);
        chk("t4_credit", {16'd0, cc_a}, 32'h0111);

        // underflow on port 3, then dispatch+done on port 0
        port_en = 4'b0001;
        done    = 4'b1000;
        @(negedge clk);
        done    = 4'b0000;
        chk("t5_err", {31'd0, er_a}, 32'd1);
        chk("t5_credit_uf", {16'd0, cc_a}, 32'h0111);
        chk("t5_sel", {30'd0, ifa.dmx_select}, 32'd0);
        s_valid = 1'b1;
        s_last  = 1'b1;
        done    = 4'b0001;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        done    = 4'b0000;
        chk("t5_cancel_credit", {16'd0, cc_a}, 32'h0111);
        chk("t5_cancel_enable", {31'd0, ifa.dmx_enable}, 32'd0);
        chk("t5_err_sticky", {31'd0, er_a}, 32'd1);
        done    = 4'b0001;
        @(negedge clk);
        done    = 4'b0000;
        chk("t5_dec_credit", {16'd0, cc_a}, 32'h0110);

        // reset in the middle of a frame
        port_en = 4'hF;
        beat(1'b1);
        chk("t6_sel_a", {30'd0, b_sel}, 32'd0);
        beat(1'b0);
        chk("t6_sel_b", {30'd0, b_sel}, 32'd1);
        beat(1'b0);
        s_valid = 1'b1;
        rst     = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        s_valid = 1'b0;
        chk("t6_enable", {31'd0, ifa.dmx_enable}, 32'd0);
        chk("t6_drop",   {31'd0, ifa.dmx_drop},   32'd0);
        chk("t6_select", {30'd0, ifa.dmx_select}, 32'd0);
        chk("t6_credit", {16'd0, cc_a}, 32'd0);
        chk("t6_err", {31'd0, er_a}, 32'd0);
        beat(1'b1);
        chk("t6_post_sel", {30'd0, b_sel}, 32'd0);

        // credit stall (CREDIT_MAX=2, no drop)
        reset_all();
        tgt     = 1;
        port_en = 4'b0001;
        beat(1'b1);
        chk("t2_sel_a", {30'd0, b_sel}, 32'd0);
        beat(1'b1);
        chk("t2_sel_b", {30'd0, b_sel}, 32'd0);
        chk("t2_credit_full", {16'd0, cc_b}, 32'd2);
        s_valid = 1'b1;
        s_last  = 1'b1;
        repeat (3) @(negedge clk);
        chk("t2_stall_enable", {31'd0, ifb.dmx_enable}, 32'd0);
        chk("t2_stall_credit", {16'd0, cc_b}, 32'd2);
        done    = 4'b0001;
        @(negedge clk);
        done    = 4'b0000;
        chk("t2_after_done_credit", {16'd0, cc_b}, 32'd1);
        chk("t2_after_done_enable", {31'd0, ifb.dmx_enable}, 32'd0);
        beat(1'b1);
        chk("t2_sel_c", {30'd0, b_sel}, 32'd0);
        chk("t2_credit_end", {16'd0, cc_b}, 32'd2);
        chk("t2_dropcnt", dc_b, 32'd0);

        // credit exhausted with drop enabled
        reset_all();
        tgt     = 2;
        port_en = 4'b0001;
        beat(1'b1);
        chk("t3_drop_a", {31'd0, b_drop}, 32'd0);
        beat(1'b1);
        chk("t3_drop_b", {31'd0, b_drop}, 32'd0);
        beat(1'b1);
        chk("t3_drop_c", {31'd0, b_drop}, 32'd1);
        chk("t3_dropcnt", dc_c, 32'd1);
        chk("t3_credit", {16'd0, cc_c}, 32'd2);
        chk("t3_gap_enable", {31'd0, ifc.dmx_enable}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
